cp0_reg_dump: RTL and testbench
===============================

CP0_REG_DUMP -- requirements
Module: cp0_reg_dump

Interface
REQ-001 Parameter: LAST_IDX, default 38, the highest flat CP0 register index scanned.
REQ-002 Parameter: SKIP_IDX, default 36, a reserved flat index that is never read or emitted.
REQ-003 Port: clk  in  1  system clock; all logic is on the rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: start  in  1  one-cycle request to begin a scan; ignored while busy=1.
REQ-006 Port: abort  in  1  terminates a scan in progress.
REQ-007 Port: busy  out  1  high from the cycle after an accepted start until done or abort.
REQ-008 Port: done  out  1  one-cycle pulse after the last beat is accepted.
REQ-009 Port: cp0Re  out  1  CP0 read strobe.
REQ-010 Port: cp0Rd  out  5  CP0 register field (rd).
REQ-011 Port: cp0Sel  out  3  CP0 select field.
REQ-012 Port: cp0Rdata  in  32  CP0 read data, valid exactly one cycle after cp0Re.
REQ-013 Port: outValid  out  1  output beat valid.
REQ-014 Port: outReady  in  1  downstream accept.
REQ-015 Port: outRegNum  out  6  flat register index of the current beat.
REQ-016 Port: outRd / outSel  out  5 / 3  the rd and sel fields of the current beat.
REQ-017 Port: outData  out  32  the captured register value.

Function
REQ-018 The index-to-(rd,sel) mapping SHALL be fixed as follows:
- 0-11 -> (n,0)
- 12 -> (12,1), 13 -> (12,2), 14 -> (12,3), 15 -> (12,0)
- 16 -> (13,0), 17 -> (14,0), 18 -> (15,1), 19 -> (15,0)
- 20 -> (16,1), 21 -> (16,2), 22 -> (16,3), 23 -> (16,0)
- 24 -> (17,0), 25 -> (18,0), 26 -> (19,0), 27 -> (23,0), 28 -> (24,0)
- 29 -> (25,0), 30 -> (25,1), 31 -> (26,0), 32 -> (27,0)
- 33 -> (28,1), 34 -> (28,0), 35 -> (29,0), 37 -> (30,0), 38 -> (31,0)
REQ-019 The state machine SHALL have the states IDLE, REQ, CAP, OUT and FIN.
REQ-020 IDLE: on start=1, clear idx to 0 and go to REQ; busy rises in the next cycle.
REQ-021 REQ: drive cp0Re=1 with the mapped cp0Rd/cp0Sel for one cycle, then go to CAP.
REQ-022 CAP: latch cp0Rdata, idx, rd and sel into the output registers, then go to OUT; outValid rises entering OUT.
REQ-023 OUT: hold all out* signals stable while outValid=1 and outReady=0.
REQ-024 On handshake in OUT with idx=LAST_IDX, go to FIN.
REQ-025 On handshake in OUT with idx<LAST_IDX, advance idx (skipping SKIP_IDX) and go to REQ.
REQ-026 FIN: pulse done=1 for one cycle, drop busy, return to IDLE.
REQ-027 Minimum cost SHALL be 3 cycles per beat with outReady held high.
REQ-028 With default parameters, a full scan SHALL emit 38 beats in 114 cycles from the accepted start to done.
REQ-029 idx SHALL never wrap.
REQ-030 The increment from 35 SHALL go directly to 37.
REQ-031 If LAST_IDX equals SKIP_IDX, the scan SHALL finish after the preceding index.
REQ-032 abort SHALL win over every other event in any non-IDLE state: next state IDLE, outValid=0, busy=0, no done pulse.
REQ-033 An abort coinciding with a handshake SHALL count that beat as delivered, with no further beats.
REQ-034 A start coinciding with abort SHALL be ignored.
REQ-035 A start in IDLE on the same cycle as done SHALL be accepted.
REQ-036 cp0Re SHALL be high only in REQ.
REQ-037 cp0Rd and cp0Sel SHALL be 0 whenever cp0Re=0.

Reset
REQ-038 Reset SHALL force the state to IDLE and idx to 0.
REQ-039 Reset SHALL drive busy, done, cp0Re, outValid, cp0Rd, cp0Sel, outRegNum, outRd, outSel and outData to 0.
REQ-040 Reset asserted mid-scan SHALL discard the scan without a done pulse.
REQ-041 start SHALL be ignored in any cycle where rst=1.

Structure
REQ-042 Shared package cp0_pkg SHALL hold:
- CP0_NUM_IDX=39 and CP0_RSVD_IDX=36
- the scan-state enum
- the rd/sel field widths
REQ-043 The mapping SHALL be a combinational sub-module cp0_idx_to_rdsel (idx[5:0] -> rd[4:0], sel[2:0]), instantiated once and unit-testable.

Verification
REQ-044 Full scan: start with outReady=1 and CP0 model returning {rd,sel,idx} -> 38 beats, done at cycle 114, idx 36 absent, beat 30 = (25,1), beat 33 = (28,1).
REQ-045 Backpressure: outReady=0 for 5 cycles at idx 12 -> outRegNum=12, outData and outRd=12/outSel=1 stable, no cp0Re until accepted.
REQ-046 Abort at idx 20 in CAP -> next cycle busy=0, outValid=0, no done; a new start begins at idx 0.
REQ-047 Reset in OUT at idx 7 -> all outputs 0 next cycle; a start asserted with rst ignored.
REQ-048 Start during busy -> no restart; beat sequence unchanged.
REQ-049 Encoder exhaustive: cp0_idx_to_rdsel for idx 0..38 except 36 -> (rd,sel) decode back to the same idx.

Source files
------------

// File: rtl/cp0_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : cp0_pkg                                                         |
// | Purpose   : Shared constants, field widths and scan-state encoding for the |
// |             CP0 register dump engine.                                      |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package cp0_pkg;

  // Flat register index space: 0..38, with 36 reserved (never read).
  localparam int CP0_NUM_IDX  = 39;
  localparam int CP0_RSVD_IDX = 36;

  // Field widths.
  localparam int CP0_IDX_W = 6;
  localparam int CP0_RD_W  = 5;
  localparam int CP0_SEL_W = 3;

  // Scan state machine.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAP  = 3'd2,
    ST_OUT  = 3'd3,
    ST_FIN  = 3'd4
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/cp0_idx_to_rdsel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : cp0_idx_to_rdsel                                                |
// | Purpose   : Combinational map from a flat CP0 register index to its        |
// |             (rd, sel) coordinates. Unmapped indices yield (0, 0).          |
// | Ports     : idx  in  [5:0]  flat register index                            |
// |             rd   out [4:0]  CP0 register number                            |
// |             sel  out [2:0]  CP0 select                                     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module cp0_idx_to_rdsel
  import cp0_pkg::*;
(
  input  logic [CP0_IDX_W-1:0] idx,
  output logic [CP0_RD_W-1:0]  rd,
  output logic [CP0_SEL_W-1:0] sel
);

  always_comb begin
    rd  = '0;
    sel = '0;
    if (idx <= 6'd11) begin
      // Low indices map one-to-one onto rd with select 0.
      rd = idx[CP0_RD_W-1:0];
    end else begin
      case (idx)
        6'd12:   begin rd = 5'd12; sel = 3'd1; end
        6'd13:   begin rd = 5'd12; sel = 3'd2; end
        6'd14:   begin rd = 5'd12; sel = 3'd3; end
        6'd15:   begin rd = 5'd12; sel = 3'd0; end
        6'd16:   begin rd = 5'd13; sel = 3'd0; end
        6'd17:   begin rd = 5'd14; sel = 3'd0; end
        6'd18:   begin rd = 5'd15; sel = 3'd1; end
        6'd19:   begin rd = 5'd15; sel = 3'd0; end
        6'd20:   begin rd = 5'd16; sel = 3'd1; end
        6'd21:   begin rd = 5'd16; sel = 3'd2; end
        6'd22:   begin rd = 5'd16; sel = 3'd3; end
        6'd23:   begin rd = 5'd16; sel = 3'd0; end
        6'd24:   begin rd = 5'd17; sel = 3'd0; end
        6'd25:   begin rd = 5'd18; sel = 3'd0; end
        6'd26:   begin rd = 5'd19; sel = 3'd0; end
        6'd27:   begin rd = 5'd23; sel = 3'd0; end
        6'd28:   begin rd = 5'd24; sel = 3'd0; end
        6'd29:   begin rd = 5'd25; sel = 3'd0; end
        6'd30:   begin rd = 5'd25; sel = 3'd1; end
        6'd31:   begin rd = 5'd26; sel = 3'd0; end
        6'd32:   begin rd = 5'd27; sel = 3'd0; end
        6'd33:   begin rd = 5'd28; sel = 3'd1; end
        6'd34:   begin rd = 5'd28; sel = 3'd0; end
        6'd35:   begin rd = 5'd29; sel = 3'd0; end
        6'd37:   begin rd = 5'd30; sel = 3'd0; end
        6'd38:   begin rd = 5'd31; sel = 3'd0; end
        default: begin rd = 5'd0;  sel = 3'd0; end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cp0_reg_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : cp0_reg_dump                                                    |
// | Purpose   : Walks the flat CP0 index space 0..LAST_IDX (skipping SKIP_IDX),|
// |             reads each register and emits it as a valid/ready beat.        |
// | Ports     : clk, rst              clock, synchronous active-high reset     |
// |             start, abort          scan control; busy, done status          |
// |             cp0Re/cp0Rd/cp0Sel    CP0 read request (data one cycle later)  |
// |             cp0Rdata              CP0 read data                            |
// |             outValid/outReady     output handshake                         |
// |             outRegNum/outRd/outSel/outData  beat payload                   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module cp0_reg_dump
  import cp0_pkg::*;
#(
  parameter int LAST_IDX = CP0_NUM_IDX - 1,
  parameter int SKIP_IDX = CP0_RSVD_IDX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 cp0Re,
  output logic [CP0_RD_W-1:0]  cp0Rd,
  output logic [CP0_SEL_W-1:0] cp0Sel,
  input  logic [31:0]          cp0Rdata,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [CP0_IDX_W-1:0] outRegNum,
  output logic [CP0_RD_W-1:0]  outRd,
  output logic [CP0_SEL_W-1:0] outSel,
  output logic [31:0]          outData
);

  // One extra bit so the index arithmetic can never wrap.
  localparam logic [CP0_IDX_W:0] C_LAST = (CP0_IDX_W+1)'(LAST_IDX);
  localparam logic [CP0_IDX_W:0] C_SKIP = (CP0_IDX_W+1)'(SKIP_IDX);

  scan_state_e            r_state;
  scan_state_e            w_state_nxt;
  logic [CP0_IDX_W-1:0]   r_idx;
  logic [CP0_IDX_W-1:0]   w_idx_nxt;
  logic [CP0_IDX_W:0]     w_idx_inc;
  logic                   w_last;
  logic                   w_capture;
  logic [CP0_RD_W-1:0]    w_map_rd;
  logic [CP0_SEL_W-1:0]   w_map_sel;

  logic [CP0_IDX_W-1:0]   r_out_num;
  logic [CP0_RD_W-1:0]    r_out_rd;
  logic [CP0_SEL_W-1:0]   r_out_sel;
  logic [31:0]            r_out_data;

  cp0_idx_to_rdsel u_idx_map (
    .idx (r_idx),
    .rd  (w_map_rd),
    .sel (w_map_sel)
  );

  // Next index, stepping over the reserved slot.
  always_comb begin
    w_idx_inc = {1'b0, r_idx} + 1'b1;
    if (w_idx_inc == C_SKIP) begin
      w_idx_inc = w_idx_inc + 1'b1;
    end
  end

  // Last beat either when idx reached LAST_IDX, or when the next index would
  // overshoot it (covers LAST_IDX landing on the reserved slot).
  assign w_last = ({1'b0, r_idx} >= C_LAST) || (w_idx_inc > C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE, ST_FIN: begin
        // FIN accepts a new start so back-to-back scans lose no cycle.
        w_state_nxt = ST_IDLE;
        if (start && !abort) begin
          w_state_nxt = ST_REQ;
          w_idx_nxt   = '0;
        end
      end
      ST_REQ: begin
        w_state_nxt = ST_CAP;
      end
      ST_CAP: begin
        w_state_nxt = ST_OUT;
        w_capture   = 1'b1;
      end
      ST_OUT: begin
        if (outReady) begin
          if (w_last) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_state_nxt = ST_REQ;
            w_idx_nxt   = w_idx_inc[CP0_IDX_W-1:0];
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Abort overrides everything outside IDLE.
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_capture   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_num  <= '0;
      r_out_rd   <= '0;
      r_out_sel  <= '0;
      r_out_data <= '0;
    end else if (w_capture) begin
      r_out_num  <= r_idx;
      r_out_rd   <= w_map_rd;
      r_out_sel  <= w_map_sel;
      r_out_data <= cp0Rdata;
    end
  end

  assign busy      = (r_state == ST_REQ) || (r_state == ST_CAP) || (r_state == ST_OUT);
  assign done      = (r_state == ST_FIN);
  assign cp0Re     = (r_state == ST_REQ);
  assign cp0Rd     = cp0Re ? w_map_rd  : '0;
  assign cp0Sel    = cp0Re ? w_map_sel : '0;
  assign outValid  = (r_state == ST_OUT);
  assign outRegNum = r_out_num;
  assign outRd     = r_out_rd;
  assign outSel    = r_out_sel;
  assign outData   = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_cp0_reg_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_cp0_reg_dump                                                 |
// | Purpose   : Self-checking bench for cp0_reg_dump with a CP0 responder,     |
// |             randomized backpressure and a table-driven expected model.     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cp0_reg_dump;

  logic        clk = 1'b0;
  logic        rst, start, abort, outReady;
  logic [31:0] cp0Rdata;
  logic        busy, done, cp0Re, outValid;
  logic [4:0]  cp0Rd, outRd;
  logic [2:0]  cp0Sel, outSel;
  logic [5:0]  outRegNum;
  logic [31:0] outData;

  logic [5:0]  ut_idx;
  logic [4:0]  ut_rd;
  logic [2:0]  ut_sel;

  always #5 clk = ~clk;

  cp0_reg_dump dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .cp0Re     (cp0Re),
    .cp0Rd     (cp0Rd),
    .cp0Sel    (cp0Sel),
    .cp0Rdata  (cp0Rdata),
    .outValid  (outValid),
    .outReady  (outReady),
    .outRegNum (outRegNum),
    .outRd     (outRd),
    .outSel    (outSel),
    .outData   (outData)
  );

  cp0_idx_to_rdsel u_map_ut (
    .idx (ut_idx),
    .rd  (ut_rd),
    .sel (ut_sel)
  );

  // Register map as rd*8+sel per flat index; -1 marks the reserved slot.
  int tab [0:38] = '{
    0, 8, 16, 24, 32, 40, 48, 56, 64, 72, 80, 88,
    97, 98, 99, 96,
    104, 112, 121, 120,
    129, 130, 131, 128,
    136, 144, 152, 184, 192,
    200, 201, 208, 216,
    225, 224, 232, -1, 240, 248
  };

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          acc_edge = 0;
  int          done_cyc = 0;
  bit          done_seen = 0;
  int          n_re = 0;
  logic [17:0] last_salt = '0;
  int          exp_q[$];
  int          beat_num[$];
  int          beat_rdsel[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [4:0] rd, input logic [2:0] sel);
    for (int i = 0; i < 39; i++) begin
      if (tab[i] == int'({rd, sel})) return i;
    end
    return 63;
  endfunction

  task automatic record_beat();
    int e;
    beat_num.push_back(int'(outRegNum));
    beat_rdsel.push_back(int'({outRd, outSel}));
    if (exp_q.size() == 0) begin
      check("extra_beat", 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check("beat_idx", 64'(outRegNum), 64'(e));
      check("beat_rdsel", 64'({outRd, outSel}), 64'(tab[e]));
      check("beat_data", 64'(outData), 64'({last_salt, 8'(tab[e]), 6'(e)}));
    end
  endtask

  // One clock: evaluate handshake before the edge, then sample #1 after it
  // and play the CP0 side (data valid exactly one cycle after cp0Re).
  task automatic step();
    bit          hs, re, stall;
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [45:0] snap;
    hs    = (outValid === 1'b1) && (outReady === 1'b1) && (rst !== 1'b1);
    if (hs) record_beat();
    re    = (cp0Re === 1'b1);
    rd    = cp0Rd;
    sel   = cp0Sel;
    stall = (outValid === 1'b1) && !outReady && !abort && !rst;
    snap  = {outRegNum, outRd, outSel, outData};
    @(posedge clk);
    #1;
    cyc++;
    if (re) begin
      last_salt = 18'($urandom);
      cp0Rdata  = {last_salt, rd, sel, 6'(decode(rd, sel))};
    end else begin
      cp0Rdata  = $urandom;
    end
    if (cp0Re === 1'b1) n_re++;
    if (cp0Re !== 1'b1) check("rdsel_when_no_re", 64'({cp0Rd, cp0Sel}), 64'(0));
    if (stall) begin
      check("hold_valid", 64'(outValid), 64'(1));
      check("hold_payload", 64'({outRegNum, outRd, outSel, outData}), 64'(snap));
      check("hold_no_re", 64'(cp0Re), 64'(0));
    end
    if (done === 1'b1) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  endtask

  task automatic begin_scan();
    exp_q.delete();
    beat_num.delete();
    beat_rdsel.delete();
    for (int i = 0; i <= 38; i++) begin
      if (i != 36) exp_q.push_back(i);
    end
    done_seen = 1'b0;
  endtask

  task automatic do_start();
    begin_scan();
    start    = 1'b1;
    acc_edge = cyc + 1;
    step();
    start    = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done_seen && k < budget) begin
      step();
      k++;
    end
    if (!done_seen) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_out(input int idx, input int budget);
    int k = 0;
    while (!((outValid === 1'b1) && (outRegNum == 6'(idx))) && k < budget) begin
      step();
      k++;
    end
    check("reach_out_idx", 64'({outValid, outRegNum}), 64'({1'b1, 6'(idx)}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    int cnt36;
    int n_re0;
    rst      = 1'b1;
    start    = 1'b1;
    abort    = 1'b0;
    outReady = 1'b0;
    cp0Rdata = '0;
    ut_idx   = '0;

    // Reset, with start held high the whole time.
    repeat (3) step();
    check("reset_outputs",
          64'({busy, done, cp0Re, outValid, cp0Rd, cp0Sel, outRegNum, outRd, outSel, outData}),
          64'(0));
    rst   = 1'b0;
    start = 1'b0;
    step();
    check("start_during_rst_ignored", 64'({busy, done}), 64'(0));

    // Mapper unit test: every mapped index decodes back to itself.
    for (int i = 0; i <= 38; i++) begin
      if (i != 36) begin
        ut_idx = 6'(i);
        #1;
        check("enc_roundtrip", 64'(decode(ut_rd, ut_sel)), 64'(i));
      end
    end

    // Full scan, outReady held high.
    outReady = 1'b1;
    do_start();
    wait_done(300);
    check("full_latency", 64'(done_cyc - acc_edge), 64'(114));
    check("full_beats", 64'(beat_num.size()), 64'(38));
    check("full_exp_left", 64'(exp_q.size()), 64'(0));
    if (beat_rdsel.size() > 33) begin
      check("beat30_rdsel", 64'(beat_rdsel[30]), 64'({5'd25, 3'd1}));
      check("beat33_rdsel", 64'(beat_rdsel[33]), 64'({5'd28, 3'd1}));
    end else begin
      check("full_beat_count_short", 64'(beat_rdsel.size()), 64'(38));
    end
    cnt36 = 0;
    foreach (beat_num[i]) if (beat_num[i] == 36) cnt36++;
    check("idx36_absent", 64'(cnt36), 64'(0));

    // Start in the same cycle as done: accepted, second scan runs in full.
    do_start();
    wait_done(300);
    check("b2b_latency", 64'(done_cyc - acc_edge), 64'(114));
    check("b2b_beats", 64'(beat_num.size()), 64'(38));
    step();
    check("done_one_cycle", 64'({done, busy}), 64'(0));

    // Backpressure for 5 cycles at idx 12.
    do_start();
    wait_out(12, 100);
    check("bp_rdsel", 64'({outRd, outSel}), 64'({5'd12, 3'd1}));
    outReady = 1'b0;
    n_re0 = n_re;
    repeat (5) step();
    check("bp_no_re", 64'(n_re - n_re0), 64'(0));
    check("bp_idx_held", 64'(outRegNum), 64'(12));
    outReady = 1'b1;
    wait_done(300);
    check("bp_beats", 64'(beat_num.size()), 64'(38));

    // Random backpressure with spurious starts while busy.
    do_start();
    k = 0;
    while (!done_seen && k < 2000) begin
      outReady = ($urandom_range(0, 3) != 0);
      start    = (busy === 1'b1) && ($urandom_range(0, 5) == 0);
      step();
      k++;
    end
    start    = 1'b0;
    outReady = 1'b1;
    check("rand_done", 64'(done_seen), 64'(1));
    check("rand_beats", 64'(beat_num.size()), 64'(38));
    check("rand_exp_left", 64'(exp_q.size()), 64'(0));
    step();

    // Abort while in CAP for idx 20, with a start on the same cycle.
    do_start();
    k = 0;
    while (!((cp0Re === 1'b1) && cp0Rd == 5'd16 && cp0Sel == 3'd1) && k < 200) begin
      step();
      k++;
    end
    check("reach_req20", 64'({cp0Re, cp0Rd, cp0Sel}), 64'({1'b1, 5'd16, 3'd1}));
    step();
    check("in_cap20", 64'({outValid, cp0Re, busy}), 64'({1'b0, 1'b0, 1'b1}));
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("abort_outputs", 64'({busy, outValid, done}), 64'(0));
    repeat (4) step();
    check("abort_no_done", 64'(done_seen), 64'(0));
    check("abort_stays_idle", 64'(busy), 64'(0));
    check("abort_beats", 64'(beat_num.size()), 64'(20));

    do_start();
    k = 0;
    while (beat_num.size() == 0 && k < 50) begin
      step();
      k++;
    end
    if (beat_num.size() > 0) check("restart_first_idx", 64'(beat_num[0]), 64'(0));
    else check("restart_no_beat", 64'(0), 64'(1));
    wait_done(300);
    step();

    // Abort coinciding with the handshake of idx 5.
    do_start();
    wait_out(5, 100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_hs_beats", 64'(beat_num.size()), 64'(6));
    if (beat_num.size() > 0) check("abort_hs_last", 64'(beat_num[beat_num.size()-1]), 64'(5));
    n_re0 = n_re;
    repeat (8) step();
    check("abort_hs_no_re", 64'(n_re - n_re0), 64'(0));
    check("abort_hs_idle", 64'({busy, outValid, done_seen}), 64'(0));
    check("abort_hs_beats_after", 64'(beat_num.size()), 64'(6));

    // Reset while in OUT at idx 7; start asserted with rst.
    do_start();
    wait_out(7, 100);
    outReady = 1'b0;
    rst   = 1'b1;
    start = 1'b1;
    step();
    check("rst_mid_outputs",
          64'({busy, done, cp0Re, outValid, cp0Rd, cp0Sel, outRegNum, outRd, outSel, outData}),
          64'(0));
    step();
    rst   = 1'b0;
    start = 1'b0;
    repeat (4) step();
    check("rst_mid_idle", 64'({busy, outValid, done_seen}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
